// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with blanking dead-time.
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter logic [15:0] CLK_DIV = 16'd50000,
    parameter logic [15:0] DEAD    = 16'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] digit_en,
    output logic [6:0] cn,
    output logic [7:0] an,
    output logic [2:0] scan_idx,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DEAD_T,
        LIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  idx_nxt;
    logic [7:0]  an_nxt;
    logic [6:0]  cn_nxt;
    logic        busy_nxt;
    logic [3:0]  dbuf [8];
    logic [3:0]  cur_val;
    logic        blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign cur_val = dbuf[scan_idx];

`ifdef SEG_SCAN_LZB_EN
    logic hi_nz;

    // Any enabled non-zero digit above the current slot stops blanking.
    always_comb begin
        hi_nz = 1'b0;
        for (int j = 1; j < 8; j++) begin
            if (3'(j) > scan_idx && digit_en[3'(j)] &&
                dbuf[3'(j)] != 4'd0)
                hi_nz = 1'b1;
        end
    end

    assign blank = (scan_idx != 3'd0) && (cur_val == 4'd0) && !hi_nz;
`else
    assign blank = 1'b0;
`endif

    // Digit buffer; a write lands on the next edge, later writes win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                dbuf[i] <= 4'd0;
        end else if (wr_en) begin
            dbuf[wr_addr] <= wr_data;
        end
    end

    // Slot sequencing; the lit pattern is latched leaving DEAD_T.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = scan_idx;
        an_nxt    = an;
        cn_nxt    = cn;
        unique case (state)
            IDLE: begin
                state_nxt = DEAD_T;
                cnt_nxt   = 16'd0;
                an_nxt    = 8'hFF;
                cn_nxt    = 7'h7F;
            end
            DEAD_T: begin
                cnt_nxt = cnt + 16'd1;
                if (cnt == DEAD - 16'd1) begin
                    state_nxt = LIT;
                    if (digit_en[scan_idx] && !blank) begin
                        an_nxt = ~(8'b1 << scan_idx);
                        cn_nxt = decode(cur_val);
                    end else begin
                        an_nxt = 8'hFF;
                        cn_nxt = 7'h7F;
                    end
                end
            end
            LIT: begin
                if (cnt == CLK_DIV - 16'd1) begin
                    state_nxt = DEAD_T;
                    cnt_nxt   = 16'd0;
                    idx_nxt   = scan_idx + 3'd1;
                    an_nxt    = 8'hFF;
                    cn_nxt    = 7'h7F;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
                an_nxt    = 8'hFF;
                cn_nxt    = 7'h7F;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            scan_idx <= 3'd0;
            an       <= 8'hFF;
            cn       <= 7'h7F;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            scan_idx <= idx_nxt;
            an       <= an_nxt;
            cn       <= cn_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
